// File: rtl/filter_out_pkg.sv
// Shared constants for the filter output buffer.
package filter_out_pkg;

  localparam int DEFAULT_DEPTH = 8;
  localparam int DATA_W        = 8;
  localparam int DROP_CNT_W    = 8;
  localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = 8'd255;

  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] value);
    if (value == DROP_CNT_MAX) begin
      return DROP_CNT_MAX;
    end else begin
      return value + 8'd1;
    end
  endfunction

endpackage

// File: rtl/out_fifo_mem.sv
// DEPTH x DATA_W register array: synchronous write, asynchronous read, no reset.
module out_fifo_mem
  import filter_out_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/filter_out_buffer.sv
// Show-ahead output FIFO behind the filter with overflow detection.
// Optional drop counter enabled by FILTER_OUT_BUF_DROP_CNT_EN.
module filter_out_buffer
  import filter_out_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [DATA_W-1:0]     in_data,
  input  logic                  flush,
  input  logic                  clr_stat,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_data,
  output logic [AW:0]           count,
  output logic                  full,
  output logic                  overflow,
  output logic [DROP_CNT_W-1:0] drop_cnt
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [AW-1:0]     wptr;
  logic [AW-1:0]     rptr;
  logic [AW:0]       count_next;
  logic [DATA_W-1:0] rdata;
  logic              push;
  logic              pop;
  logic              drop;

  assign out_valid = (count != {(AW+1){1'b0}});
  assign pop       = out_valid & out_ready;
  assign push      = in_valid & (~full | pop);
  // A sample lost to flush is discarded silently, not counted as a drop.
  assign drop      = in_valid & full & ~pop & ~flush;

  out_fifo_mem #(.DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .we    (push & ~flush),
    .waddr (wptr),
    .wdata (in_data),
    .raddr (rptr),
    .rdata (rdata)
  );

  assign out_data = out_valid ? rdata : {DATA_W{1'b0}};

  always_comb begin
    count_next = count;
    if (flush) begin
      count_next = {(AW+1){1'b0}};
    end else begin
      case ({push, pop})
        2'b10:   count_next = count + {{AW{1'b0}}, 1'b1};
        2'b01:   count_next = count - {{AW{1'b0}}, 1'b1};
        default: count_next = count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= {AW{1'b0}};
      rptr  <= {AW{1'b0}};
      count <= {(AW+1){1'b0}};
      full  <= 1'b0;
    end else if (flush) begin
      wptr  <= {AW{1'b0}};
      rptr  <= {AW{1'b0}};
      count <= {(AW+1){1'b0}};
      full  <= 1'b0;
    end else begin
      if (push) begin
        wptr <= wptr + {{(AW-1){1'b0}}, 1'b1};
      end
      if (pop) begin
        rptr <= rptr + {{(AW-1){1'b0}}, 1'b1};
      end
      count <= count_next;
      full  <= (count_next == DEPTH_C);
    end
  end

  // A drop in the same cycle as clr_stat wins over the clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (clr_stat) begin
      overflow <= 1'b0;
    end
  end

`ifdef FILTER_OUT_BUF_DROP_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      drop_cnt <= {DROP_CNT_W{1'b0}};
    end else if (drop) begin
      drop_cnt <= clr_stat ? {{(DROP_CNT_W-1){1'b0}}, 1'b1} : sat_inc(drop_cnt);
    end else if (clr_stat) begin
      drop_cnt <= {DROP_CNT_W{1'b0}};
    end
  end
`else
  assign drop_cnt = {DROP_CNT_W{1'b0}};
`endif

endmodule
